// File: rtl/fir_pkg.sv
// Shared constants for the streaming FIR: default coefficient table,
// legal parameter ranges and elaboration-time helpers.
package fir_pkg;

    localparam int unsigned COEF_TABLE_N  = 32;
    localparam int unsigned TAPS_MIN      = 2;
    localparam int unsigned TAPS_MAX      = 32;
    localparam int unsigned OUT_SHIFT_MIN = 1;

    // Symmetric 9-tap low-pass; unused entries stay zero.
    localparam logic signed [15:0] DEFAULT_COEF [COEF_TABLE_N] = '{
        16'sh04F6, 16'sh0AE4, 16'sh1089, 16'sh1496, 16'sh160F, 16'sh1496, 16'sh1089, 16'sh0AE4,
        16'sh04F6, 16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000,
        16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000,
        16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000
    };

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

    function automatic int unsigned out_shift_max(input int unsigned data_w, input int unsigned coef_w);
        return data_w + coef_w - 1;
    endfunction

    // Number of terms present at a given adder-tree level.
    function automatic int unsigned level_terms(input int unsigned n, input int unsigned lvl);
        return (n + (32'd1 << lvl) - 32'd1) >> lvl;
    endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// Pairwise adder tree. All levels but the last are registered; the last
// pairwise add is returned combinationally so the caller can register it.
module fir_adder_tree
    import fir_pkg::*;
#(
    parameter  int unsigned N_TERMS = 9,
    parameter  int unsigned IN_W    = 32,
    localparam int unsigned LEVELS  = clog2(N_TERMS),
    localparam int unsigned SUM_W   = IN_W + LEVELS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_i,
    input  logic [N_TERMS-1:0][IN_W-1:0] terms_i,
    output logic                         valid_c,
    output logic signed [SUM_W-1:0]      sum_c
);

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int unsigned N_IN  = level_terms(N_TERMS, l);
        localparam int unsigned N_OUT = level_terms(N_TERMS, l + 1);

        logic signed [SUM_W-1:0] in_c   [N_IN];
        logic signed [SUM_W-1:0] pair_c [N_OUT];
        logic                    in_vld_c;

        if (l == 0) begin : g_src
            for (genvar k = 0; k < N_IN; k++) begin : g_ext
                assign in_c[k] = SUM_W'($signed(terms_i[k]));
            end
            assign in_vld_c = valid_i;
        end else begin : g_src
            assign in_c     = g_lvl[l-1].g_reg.out_q;
            assign in_vld_c = g_lvl[l-1].g_reg.vld_q;
        end

        // An odd leftover term passes through unmodified.
        for (genvar j = 0; j < N_OUT; j++) begin : g_pair
            if (2 * j + 1 < N_IN) begin : g_add
                assign pair_c[j] = in_c[2*j] + in_c[2*j+1];
            end else begin : g_pass
                assign pair_c[j] = in_c[2*j];
            end
        end

        if (l + 1 < LEVELS) begin : g_reg
            logic signed [SUM_W-1:0] out_q [N_OUT];
            logic                    vld_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_q <= '{default: '0};
                    vld_q <= 1'b0;
                end else begin
                    out_q <= pair_c;
                    vld_q <= in_vld_c;
                end
            end
        end
    end

    assign sum_c   = g_lvl[LEVELS-1].pair_c[0];
    assign valid_c = g_lvl[LEVELS-1].in_vld_c;

endmodule

// File: rtl/fir_stream.sv
// Streaming FIR with double-buffered coefficients, registered products,
// pipelined adder tree, and rounded/saturated registered output.
module fir_stream
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned COEF_W    = 16,
    parameter int unsigned TAPS      = 9,
    parameter int unsigned OUT_SHIFT = 14,
    parameter int unsigned OUT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     coef_we,
    input  logic [4:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    input  logic                     coef_swap,
    output logic                     out_valid,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_sat
);

    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam int unsigned ACC_W  = PROD_W + clog2(TAPS);
    localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'(1) << (OUT_SHIFT - 1);
    localparam logic signed [ACC_W-1:0] OUT_MAX  = (ACC_W'(1) << (OUT_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] OUT_MIN  = -(ACC_W'(1) << (OUT_W - 1));

    if (TAPS < TAPS_MIN || TAPS > TAPS_MAX || OUT_SHIFT < OUT_SHIFT_MIN ||
        OUT_SHIFT > out_shift_max(DATA_W, COEF_W)) begin : g_param_check
        $error("fir_stream: parameter outside legal range");
    end

    logic signed [DATA_W-1:0]    taps_q   [TAPS];
    logic signed [DATA_W-1:0]    taps_d   [TAPS];
    logic signed [COEF_W-1:0]    shadow_q [TAPS];
    logic signed [COEF_W-1:0]    shadow_d [TAPS];
    logic signed [COEF_W-1:0]    active_q [TAPS];
    logic signed [COEF_W-1:0]    active_d [TAPS];
    logic [TAPS-1:0][PROD_W-1:0] prod_q, prod_d;
    logic                        tap_vld_q, prod_vld_q;
    logic signed [ACC_W-1:0]     acc_c, rnd_c, shr_c;
    logic                        acc_vld_c;
    logic signed [OUT_W-1:0]     out_data_q, out_data_d;
    logic                        out_sat_q, out_sat_d, out_valid_q;

    // Delay line, shadow write-then-swap, and products against the active bank.
    always_comb begin
        taps_d   = taps_q;
        shadow_d = shadow_q;
        active_d = active_q;
        prod_d   = '0;
        if (in_valid) begin
            taps_d[0] = in_data;
            for (int k = 1; k < TAPS; k++) taps_d[k] = taps_q[k-1];
        end
        for (int k = 0; k < TAPS; k++) begin
            if (coef_we && coef_addr == 5'(k)) shadow_d[k] = coef_wdata;
        end
        if (coef_swap) active_d = shadow_d;
        for (int k = 0; k < TAPS; k++) begin
            prod_d[k] = PROD_W'(taps_q[k]) * PROD_W'(active_q[k]);
        end
    end

    fir_adder_tree #(
        .N_TERMS (TAPS),
        .IN_W    (PROD_W)
    ) u_tree (
        .clk     (clk),
        .rst     (rst),
        .valid_i (prod_vld_q),
        .terms_i (prod_q),
        .valid_c (acc_vld_c),
        .sum_c   (acc_c)
    );

    // Round half-up, arithmetic shift, clamp to the output range.
    always_comb begin
        rnd_c      = acc_c + RND_BIAS;
        shr_c      = rnd_c >>> OUT_SHIFT;
        out_data_d = OUT_W'(shr_c);
        out_sat_d  = 1'b0;
        if (shr_c > OUT_MAX) begin
            out_data_d = OUT_W'(OUT_MAX);
            out_sat_d  = 1'b1;
        end else if (shr_c < OUT_MIN) begin
            out_data_d = OUT_W'(OUT_MIN);
            out_sat_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                taps_q[k]   <= '0;
                shadow_q[k] <= COEF_W'(DEFAULT_COEF[k]);
                active_q[k] <= COEF_W'(DEFAULT_COEF[k]);
            end
            tap_vld_q   <= 1'b0;
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            taps_q      <= taps_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            tap_vld_q   <= in_valid;
            prod_q      <= prod_d;
            prod_vld_q  <= tap_vld_q;
            out_valid_q <= acc_vld_c;
            if (acc_vld_c) begin
                out_data_q <= out_data_d;
                out_sat_q  <= out_sat_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_fir_stream.sv
// Scoreboard bench for fir_stream: a stimulus process feeds a behavioural
// model that queues expected outputs; a monitor pops and compares them.
module tb_fir_stream;

    localparam int TAPS      = 9;
    localparam int OUT_SHIFT = 14;
    localparam int LAT       = 6;
    localparam int OUT_MAXV  = 32767;
    localparam int OUT_MINV  = -32768;

    typedef struct {
        int cyc;
        int data;
        bit sat;
    } exp_t;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic [15:0]        in_data;
    logic               coef_we;
    logic [4:0]         coef_addr;
    logic [15:0]        coef_wdata;
    logic               coef_swap;
    logic               out_valid;
    logic signed [15:0] out_data;
    logic               out_sat;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];
    int   hist[$];
    int   shadow_m [32];
    int   active_m [32];
    int   last_data = 0;
    bit   last_sat = 1'b0;
    int   def_coef [TAPS] = '{32'h04F6, 32'h0AE4, 32'h1089, 32'h1496, 32'h160F,
                              32'h1496, 32'h1089, 32'h0AE4, 32'h04F6};

    fir_stream #(
        .DATA_W    (16),
        .COEF_W    (16),
        .TAPS      (TAPS),
        .OUT_SHIFT (OUT_SHIFT),
        .OUT_W     (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .coef_swap  (coef_swap),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sat    (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input bit ok, input longint act, input longint exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endfunction

    // Reference: y = sum of the last TAPS accepted samples times the bank in
    // force after this edge, rounded half-up and clamped to 16 bits.
    task automatic model_edge(input logic v, input logic [15:0] d, input logic we,
                              input logic [4:0] a, input logic [15:0] wd, input logic sw,
                              input logic r, input int p);
        longint acc;
        exp_t   e;
        if (r) begin
            q.delete();
            hist.delete();
            last_data = 0;
            last_sat  = 1'b0;
            for (int k = 0; k < 32; k++) begin
                shadow_m[k] = 0;
                if (k < TAPS) shadow_m[k] = def_coef[k];
            end
            active_m = shadow_m;
            return;
        end
        if (we && int'(a) < TAPS) shadow_m[a] = int'($signed(wd));
        if (sw) active_m = shadow_m;
        if (v) begin
            hist.push_front(int'($signed(d)));
            if (hist.size() > TAPS) void'(hist.pop_back());
            acc = 0;
            for (int k = 0; k < hist.size(); k++) acc += longint'(hist[k]) * longint'(active_m[k]);
            acc = (acc + (longint'(1) <<< (OUT_SHIFT - 1))) >>> OUT_SHIFT;
            e.cyc = p + LAT;
            e.sat = 1'b0;
            if (acc > OUT_MAXV) begin
                e.data = OUT_MAXV;
                e.sat  = 1'b1;
            end else if (acc < OUT_MINV) begin
                e.data = OUT_MINV;
                e.sat  = 1'b1;
            end else begin
                e.data = int'(acc);
            end
            q.push_back(e);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic we, input logic [4:0] a,
                         input logic [15:0] wd, input logic sw, input logic r);
        int p;
        rst = r; in_valid = v; in_data = d;
        coef_we = we; coef_addr = a; coef_wdata = wd; coef_swap = sw;
        p = cyc;
        @(posedge clk);
        model_edge(v, d, we, a, wd, sw, r, p);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        drive(1'b1, d, 1'b0, 5'd0, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'd0, 1'b0, 5'd0, 16'd0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   want_v;
        want_v = (q.size() > 0) && (q[0].cyc <= cyc);
        check("out_valid", out_valid === want_v, longint'(out_valid), longint'(want_v));
        if (out_valid === 1'b1 && q.size() > 0) begin
            e = q.pop_front();
            check("latency", cyc == e.cyc, cyc, e.cyc);
            check("out_data", out_data == e.data, out_data, e.data);
            check("out_sat", out_sat === e.sat, longint'(out_sat), longint'(e.sat));
            last_data = e.data;
            last_sat  = e.sat;
        end else if (out_valid !== 1'b1) begin
            if (want_v) void'(q.pop_front());
            check("hold_data", out_data == last_data, out_data, last_data);
            check("hold_sat", out_sat === last_sat, longint'(out_sat), longint'(last_sat));
        end
    end

    initial begin
        logic        v, we, sw;
        logic [15:0] d, wd;
        logic [4:0]  a;

        for (int i = 0; i < 3; i++) drive(1'b0, 16'd0, 1'b0, 5'd0, 16'd0, 1'b0, 1'b1);

        // Impulse with default coefficients.
        send(16'h4000);
        for (int i = 0; i < 12; i++) send(16'h0000);
        idle(8);

        // Positive and negative DC saturation.
        for (int i = 0; i < 20; i++) send(16'h4000);
        for (int i = 0; i < 20; i++) send(16'h8000);
        for (int i = 0; i < 12; i++) send(16'h0000);

        // Gapped impulse: valid on alternate cycles.
        send(16'h4000);
        idle(1);
        for (int i = 0; i < 11; i++) begin
            send(16'h0000);
            idle(1);
        end
        idle(8);

        // Reload as passthrough, out-of-range write ignored, then swap.
        drive(1'b0, 16'd0, 1'b1, 5'd0, 16'h4000, 1'b0, 1'b0);
        for (int k = 1; k < TAPS; k++) drive(1'b0, 16'd0, 1'b1, 5'(k), 16'h0000, 1'b0, 1'b0);
        drive(1'b0, 16'd0, 1'b1, 5'd31, 16'h7FFF, 1'b0, 1'b0);
        drive(1'b0, 16'd0, 1'b0, 5'd0, 16'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 12; i++) send(16'(i));

        // Write, swap and sample in the same cycle.
        drive(1'b1, 16'd100, 1'b1, 5'd1, 16'h4000, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) send(16'($urandom_range(0, 2000)) - 16'd1000);

        // Random traffic with random coefficient writes and swaps.
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 9) < 7);
            d  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2047)) - 16'd1024;
            we = ($urandom_range(0, 4) == 0);
            a  = 5'($urandom_range(0, 31));
            wd = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 8191)) - 16'd4096;
            sw = ($urandom_range(0, 19) == 0);
            drive(v, d, we, a, wd, sw, 1'b0);
        end

        // One-cycle reset in the middle of a continuous ramp.
        for (int i = 1; i <= 10; i++) send(16'(i * 100));
        drive(1'b1, 16'd1100, 1'b0, 5'd0, 16'd0, 1'b0, 1'b1);
        for (int i = 12; i < 32; i++) send(16'(i * 100));
        idle(20);

        check("drain_empty", q.size() == 0, q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
